// File: rtl/spi_regbank_periph_if.sv
// SPI pin bundle for spi_regbank_periph.
//   sclk    : SPI clock from the controller, asynchronous to the system clock
//   ncs     : chip select, active-low
//   copi    : controller-out / peripheral-in data
//   cipo    : peripheral-out / controller-in data
//   cipo_oe : high while the peripheral drives cipo
// The master modport is the controller side, the slave modport the peripheral.
interface spi_regbank_periph_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regbank_periph.sv
// SPI mode-0 peripheral with a read/write bank of NUM_REGS registers.
// All SPI pins are oversampled in the clk domain; nothing runs on sclk.
// Frame: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, MSB first.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   spi       : SPI pin bundle (slave side)
//   reg_q     : flattened register contents, register k at [k*DATA_W +: DATA_W]
//   wr_strobe : one-cycle pulse when a write commits
//   wr_addr   : address of the committed write, valid with wr_strobe
//
// state | meaning
// IDLE  | waiting for an ncs fall (only once ncs has been seen high)
// CMD   | shifting in the R/W bit and the address
// DATA  | shifting write data in, or read data out on cipo
// OVF   | frame too long; ignore sclk until ncs rises
module spi_regbank_periph #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  spi_regbank_periph_if.slave          spi,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int CNT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, OVF} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  logic                   armed;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_W:0]        cmd_sr;
  logic [ADDR_W:0]        cmd_nxt;
  logic [DATA_W-1:0]      rx_sr;
  logic [DATA_W-1:0]      tx_sr;
  logic [DATA_W-1:0]      rd_data;
  logic [DATA_W-1:0]      regs [NUM_REGS];

  logic                   rw;
  logic [ADDR_W-1:0]      addr;
  logic                   commit;

  // Sync flops reset low so that ncs held low through reset never looks
  // like a fresh fall: armed needs a real high level first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ncs_sync  <= '0;
      copi_sync <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign ncs_s    = ncs_sync[SYNC_STAGES-1];
  assign copi_s   = copi_sync[SYNC_STAGES-1];
  assign ncs_rise = ncs_s & ~ncs_d;
  assign ncs_fall = ~ncs_s & ncs_d;
  // An ncs rise wins over an sclk edge seen in the same cycle.
  assign sclk_rise = sclk_s & ~sclk_d & ~ncs_rise;
  assign sclk_fall = ~sclk_s & sclk_d & ~ncs_rise;

  assign rw      = cmd_sr[ADDR_W];
  assign addr    = cmd_sr[ADDR_W-1:0];
  assign cmd_nxt = {cmd_sr[ADDR_W-1:0], copi_s};

  assign commit = ncs_rise && (state == DATA) && rw &&
                  (cnt == CNT_W'(DATA_W)) && (addr < ADDR_W'(NUM_REGS));

  // Read source uses the address as it will be once the last address bit lands.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_nxt[ADDR_W-1:0] == ADDR_W'(k)) rd_data = regs[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ncs_fall && armed) state_nxt = CMD;
      CMD:  if (sclk_rise && cnt == CNT_W'(ADDR_W)) state_nxt = DATA;
      DATA: if (sclk_rise && cnt == CNT_W'(DATA_W)) state_nxt = OVF;
      OVF:  state_nxt = OVF;
      default: state_nxt = IDLE;
    endcase
    if (ncs_rise) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      cnt       <= '0;
      cmd_sr    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (ncs_s) armed <= 1'b1;

      if (commit) begin
        wr_strobe <= 1'b1;
        wr_addr   <= addr;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (addr == ADDR_W'(k)) regs[k] <= rx_sr;
        end
      end

      unique case (state)
        IDLE: cnt <= '0;
        CMD: begin
          if (sclk_rise) begin
            cmd_sr <= cmd_nxt;
            if (cnt == CNT_W'(ADDR_W)) begin
              cnt   <= '0;
              tx_sr <= rd_data;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sclk_rise && cnt != CNT_W'(DATA_W)) begin
            rx_sr <= {rx_sr[DATA_W-2:0], copi_s};
            cnt   <= cnt + 1'b1;
          end
          // No shift on the fall that precedes the first data rise, so the
          // MSB is still presented when the controller samples it.
          if (sclk_fall && cnt != '0) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
        OVF: ;
        default: ;
      endcase
    end
  end

  assign spi.cipo_oe = (state == DATA) && !rw;
  assign spi.cipo    = spi.cipo_oe & tx_sr[DATA_W-1];

  always_comb begin
    reg_q = '0;
    for (int k = 0; k < NUM_REGS; k++) reg_q[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule

// File: doc/spi_regbank_periph.md
# spi_regbank_periph

Parametrised SPI (mode 0) peripheral with a bank of `NUM_REGS` registers, each `DATA_W` bits wide, and full read/write support. It replaces the write-only 5×8 onboarding register block and feeds the PWM and output-enable logic through a flattened register bus. All SPI pins are oversampled in the `clk` domain; there is no logic clocked by `sclk`.

## Interface

Parameters:
- `NUM_REGS`, 5: number of implemented registers, at addresses 0..NUM_REGS-1.
- `ADDR_W`, 7: address field width in the frame.
- `DATA_W`, 8: register and data field width.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `ncs` and `copi` (minimum 2).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `ncs` in 1: chip select, active-low.
- `copi` in 1: controller-out data.
- `cipo` out 1: peripheral-out data.
- `cipo_oe` out 1: high while `cipo` is driven.
- `reg_q` out NUM_REGS*DATA_W: register contents; register *k* is at bits [k*DATA_W +: DATA_W].
- `wr_strobe` out 1: one-cycle pulse when a write commits.
- `wr_addr` out ADDR_W: address of the committed write; valid while `wr_strobe` is high.

## Operation

Frame format:
- Bits are sent MSB first, mode 0: sampled on the `sclk` rising edge, changed on the falling edge.
- Order: 1 R/W bit (1 = write, 0 = read), then `ADDR_W` address bits, then `DATA_W` data bits.
- A valid frame is exactly `1+ADDR_W+DATA_W` rising edges inside one `ncs`-low window.

Edge detection:
- `sclk`, `ncs` and `copi` each pass through `SYNC_STAGES` flops.
- Edges are detected by comparing the last synchronised stage with one additional flop.

States:
- IDLE: wait for a detected `ncs` fall, then go to CMD. Entry requires the `armed` flag, which is set once synchronised `ncs` is seen high. `armed` clears on reset.
- CMD: shift in the R/W bit and address bits. After rising edge #(1+ADDR_W), go to DATA.
- DATA:
  - Write: shift `DATA_W` bits into the receive register.
  - Read: shift out data (see below).
  - A further rising edge beyond the frame length goes to OVF.
- OVF: ignore all `sclk` activity until `ncs` rises.
- Any detected `ncs` rise returns to IDLE from every state.

Write commit, evaluated on a detected `ncs` rise:
- Commit only if the state is DATA, R/W=1, the data bit count equals `DATA_W`, and the address is < `NUM_REGS`.
- On commit, write the data to the register, pulse `wr_strobe` and drive `wr_addr`.
- Otherwise nothing changes: short frame, OVF, out-of-range address, or read.

Read:
- On the CMD→DATA transition with R/W=0, load the transmit shift register with reg[addr], or 0 if the address is out of range.
- `cipo` equals the shift register MSB.
- The shift register shifts left on each detected `sclk` fall that follows at least one data-phase rise, so the MSB stays valid for the first data rise.
- Reads never modify registers.

`cipo_oe` is 1 only in DATA with R/W=0; `cipo` is 0 whenever `cipo_oe` is 0.

Simultaneous events:
- A detected `ncs` rise takes priority over an `sclk` edge detected in the same cycle; that `sclk` edge is dropped.

## Timing

- Synchroniser plus edge detect latency: `SYNC_STAGES`+1 `clk` cycles from a pin edge to its detect pulse.
- Each `sclk` high or low phase must last ≥ `SYNC_STAGES`+2 `clk` cycles.
- `ncs` setup before the first `sclk` rise, and hold after the last `sclk` fall, must each be ≥ `SYNC_STAGES`+2 cycles.
- `reg_q`, `wr_strobe` and `wr_addr` update in the `clk` cycle after the `ncs` rise is detected. `wr_strobe` is high for exactly 1 cycle.
- `cipo` update lags the `sclk` fall at the pin by `SYNC_STAGES`+2 cycles.
- Reset values: all registers 0, `reg_q`=0, `cipo`=0, `cipo_oe`=0, `wr_strobe`=0, `wr_addr`=0, state IDLE, `armed`=0.
- Reset mid-frame: discard the partial frame. The next frame is accepted only after `ncs` has been seen high.

## Test plan

All scenarios use the default parameters (5 registers, `ADDR_W`=7, `DATA_W`=8, 16-bit frames).

- Write 0xF0 to address 0x00, sending frame bits 1,0000000,11110000 → `reg_q[7:0]`=0xF0; `wr_strobe` high for 1 cycle with `wr_addr`=0; all other bits of `reg_q` stay 0.
- Write 0xA5 to address 0x02, then read address 0x02 → during the data phase `cipo_oe`=1 and the bits sampled on `sclk` rises are 1,0,1,0,0,1,0,1; `reg_q` is unchanged after the read.
- Short frame (10 bits) and long frame (20 bits), each a write of 0xFF to address 0x01 → `reg_q[15:8]` stays 0x00 and no `wr_strobe` occurs.
- Write 0x55 to address 0x05 (out of range), then read address 0x05 → no `wr_strobe`, `reg_q` unchanged, read returns 0x00.
- Assert `rst` for 1 cycle after 9 bits of a write frame → all outputs 0. With `ncs` held low through reset, further `sclk` pulses have no effect. After `ncs` goes high and low again, a write of 0x3C to address 0x04 succeeds, giving `reg_q[39:32`]=0x3C.
- Back-to-back writes of 0x11 to address 0x03 and 0x22 to address 0x04, with minimum `ncs` gap (`SYNC_STAGES`+2 cycles) → two distinct `wr_strobe` pulses, `reg_q[31:24]`=0x11 and `reg_q[39:32]`=0x22.
